sr_latch_sequencer: RTL and testbench

- Synchronous controller that drives an external NOR-type SR / gated-D latch cell under test.
- Accepts latch commands over a valid/ready handshake and sequences set, reset, enable and d pulses with programmable pulse and settle widths.
- Never drives set and reset together, so the forbidden input state cannot occur.
- Synchronises the asynchronous Q/Qbar outputs, checks them against the expected value, and returns one response per command.

---
 rtl/sr_latch_seq_pkg.sv | 55 +++++
 rtl/sr_latch_sequencer_sync2.sv | 24 ++
 rtl/sr_latch_sequencer.sv | 254 +++++++++++++++++++++++++
 tb/tb_sr_latch_sequencer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sr_latch_seq_pkg.sv
// Shared types and helpers for the SR / gated-D latch sequencer.
// Optional build macro: SEQ_RETRY_EN (retry on mismatch, adds rsp_retries).
package sr_latch_seq_pkg;

    // Command opcodes as carried on cmd_op.
    typedef enum logic [1:0] {
        OP_HOLD  = 2'b00,
        OP_SET   = 2'b01,
        OP_RESET = 2'b10,
        OP_WRITE = 2'b11
    } op_e;

    // Response codes as carried on rsp_err.
    typedef enum logic [1:0] {
        ERR_OK       = 2'b00,
        ERR_MISMATCH = 2'b01,
        ERR_INVALID  = 2'b10
    } err_e;

    // Sequencer states, visited in this order; HOLD skips PULSE.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_PULSE  = 3'd2,
        ST_SETTLE = 3'd3,
        ST_CHECK  = 3'd4
    } state_e;

    // Value the latch should hold once the command has been applied.
    function automatic logic expected_q(input op_e op, input logic d, input logic shadow);
        logic exp;
        case (op)
            OP_SET:   exp = 1'b1;
            OP_RESET: exp = 1'b0;
            OP_WRITE: exp = d;
            default:  exp = shadow;
        endcase
        return exp;
    endfunction

    // An illegal Q==Qbar pair outranks a plain value mismatch.
    function automatic err_e classify(input logic q, input logic qbar,
                                      input logic exp, input logic check_en);
        err_e err;
        if (q == qbar) begin
            err = ERR_INVALID;
        end else if (check_en && (q != exp)) begin
            err = ERR_MISMATCH;
        end else begin
            err = ERR_OK;
        end
        return err;
    endfunction

endpackage

// File: rtl/sr_latch_sequencer_sync2.sv
// Two-flop synchroniser for the asynchronous latch outputs.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic meta;

    // Shift the asynchronous input through two flops.
    // NOTE: non-blocking assignments make meta and dout sample together, so
    // the two flops form a real two-stage chain instead of collapsing into one.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            dout <= 1'b0;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end

endmodule

// File: rtl/sr_latch_sequencer.sv
// Sequencer that drives an external NOR SR / gated-D latch cell, then checks
// the synchronised Q/Qbar against the expected value and returns a response.
// Set and reset are never driven together; enable never overlaps either.
// Optional build macro: SEQ_RETRY_EN -- on a mismatch the pulse is repeated up
// to MAX_RETRY times before responding, and rsp_retries reports the count.
module sr_latch_sequencer
    import sr_latch_seq_pkg::*;
#(
    parameter int PULSE_CYC  = 2,
    parameter int SETTLE_CYC = 3,
    parameter int CNT_W      = 4,
    parameter int MAX_RETRY  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic       cmd_d,
    output logic       latch_set,
    output logic       latch_reset,
    output logic       latch_enable,
    output logic       latch_d,
    input  logic       latch_q,
    input  logic       latch_qbar,
    output logic       rsp_valid,
    output logic       rsp_q,
    output logic [1:0] rsp_err,
`ifdef SEQ_RETRY_EN
    output logic [1:0] rsp_retries,
`endif
    output logic       busy
);

    // Reject parameter sets the counter or the synchroniser cannot honour.
    if (PULSE_CYC < 1 || PULSE_CYC > (1 << CNT_W) - 1) begin : g_bad_pulse
        $error("PULSE_CYC must lie in 1..2**CNT_W-1");
    end
    if (SETTLE_CYC < 2 || SETTLE_CYC > (1 << CNT_W) - 1) begin : g_bad_settle
        $error("SETTLE_CYC must lie in 2..2**CNT_W-1");
    end
    if (MAX_RETRY < 0 || MAX_RETRY > 3) begin : g_bad_retry
        $error("MAX_RETRY must fit the 2-bit retry count");
    end

    // Counter loads: a state lasting N cycles is entered with N-1.
    localparam logic [CNT_W-1:0] PULSE_LOAD  = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    state_e           state;
    state_e           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    op_e  op_r;
    logic d_r;
    logic shadow;
    logic shadow_valid;

    logic set_next;
    logic reset_next;
    logic enable_next;
    logic d_next;

    logic q_sync;
    logic qbar_sync;

    logic accept;
    logic respond;
    logic exp_q;
    logic check_en;
    err_e err_now;

`ifdef SEQ_RETRY_EN
    localparam logic [1:0] RETRY_LIMIT = 2'(MAX_RETRY);
    logic [1:0] retry_cnt;
    logic       retry;
`endif

    sync2 u_sync_q (
        .clk  (clk),
        .rst  (rst),
        .din  (latch_q),
        .dout (q_sync)
    );

    sync2 u_sync_qbar (
        .clk  (clk),
        .rst  (rst),
        .din  (latch_qbar),
        .dout (qbar_sync)
    );

    assign cmd_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);

    // Handshake and result evaluation for the command in flight.
    always_comb begin
        accept   = cmd_valid && (state == ST_IDLE);
        exp_q    = expected_q(op_r, d_r, shadow);
        // A hold with no earlier write has nothing to compare against.
        check_en = (op_r != OP_HOLD) || shadow_valid;
        err_now  = classify(q_sync, qbar_sync, exp_q, check_en);
    end

    // Next-state and counter logic; each state entry reloads the counter.
    // NOTE: every output of this block gets a default first, so no path leaves
    // a variable unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        respond    = 1'b0;
`ifdef SEQ_RETRY_EN
        retry      = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_next = ST_SETUP;
                    cnt_next   = '0;
                end
            end
            ST_SETUP: begin
                if (op_r == OP_HOLD) begin
                    state_next = ST_SETTLE;
                    cnt_next   = SETTLE_LOAD;
                end else begin
                    state_next = ST_PULSE;
                    cnt_next   = PULSE_LOAD;
                end
            end
            ST_PULSE: begin
                if (cnt == '0) begin
                    state_next = ST_SETTLE;
                    cnt_next   = SETTLE_LOAD;
                end else begin
                    cnt_next = cnt - CNT_ONE;
                end
            end
            ST_SETTLE: begin
                if (cnt == '0) begin
                    state_next = ST_CHECK;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt - CNT_ONE;
                end
            end
            ST_CHECK: begin
`ifdef SEQ_RETRY_EN
                if ((err_now == ERR_MISMATCH) && (retry_cnt < RETRY_LIMIT)) begin
                    retry      = 1'b1;
                    state_next = ST_SETUP;
                    cnt_next   = '0;
                end else begin
                    respond    = 1'b1;
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end
`else
                respond    = 1'b1;
                state_next = ST_IDLE;
                cnt_next   = '0;
`endif
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Latch drives decoded from the next state so they leave glitch-free flops.
    // Only PULSE raises a drive, and only the one matching the registered op.
    always_comb begin
        set_next    = 1'b0;
        reset_next  = 1'b0;
        enable_next = 1'b0;
        d_next      = latch_d;
        case (state_next)
            ST_SETUP: begin
                // On the accept edge op/d are still being registered.
                d_next = (state == ST_IDLE) ? cmd_d : d_r;
            end
            ST_PULSE: begin
                set_next    = (op_r == OP_SET);
                reset_next  = (op_r == OP_RESET);
                enable_next = (op_r == OP_WRITE);
            end
            default: begin
            end
        endcase
    end

    // State, counter, drives, command capture, response and shadow registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            latch_set    <= 1'b0;
            latch_reset  <= 1'b0;
            latch_enable <= 1'b0;
            latch_d      <= 1'b0;
            op_r         <= OP_HOLD;
            d_r          <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_q        <= 1'b0;
            rsp_err      <= ERR_OK;
            shadow       <= 1'b0;
            shadow_valid <= 1'b0;
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            latch_set    <= set_next;
            latch_reset  <= reset_next;
            latch_enable <= enable_next;
            latch_d      <= d_next;
            rsp_valid    <= respond;
            if (accept) begin
                op_r <= op_e'(cmd_op);
                d_r  <= cmd_d;
            end
            if (respond) begin
                rsp_q   <= q_sync;
                rsp_err <= err_now;
                // The shadow tracks what was commanded, even if the cell failed.
                if (op_r != OP_HOLD) begin
                    shadow       <= exp_q;
                    shadow_valid <= 1'b1;
                end
            end
        end
    end

`ifdef SEQ_RETRY_EN
    // Count retries of the current command and report them with the response.
    always_ff @(posedge clk) begin
        if (rst) begin
            retry_cnt   <= 2'd0;
            rsp_retries <= 2'd0;
        end else begin
            if (accept) begin
                retry_cnt <= 2'd0;
            end else if (retry) begin
                retry_cnt <= retry_cnt + 2'd1;
            end
            if (respond) begin
                rsp_retries <= retry_cnt;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sr_latch_sequencer.sv
// Directed bench for sr_latch_sequencer driving a behavioural NOR latch with
// injectable output faults. Honours SEQ_RETRY_EN when the design is built with it.
module tb_sr_latch_sequencer;

`ifdef SEQ_RETRY_EN
    localparam bit RETRY = 1'b1;
`else
    localparam bit RETRY = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic       cmd_d;
    logic       latch_set;
    logic       latch_reset;
    logic       latch_enable;
    logic       latch_d;
    logic       latch_q;
    logic       latch_qbar;
    logic       rsp_valid;
    logic       rsp_q;
    logic [1:0] rsp_err;
`ifdef SEQ_RETRY_EN
    logic [1:0] rsp_retries;
`endif
    logic       busy;

    int errors;
    int checks;

    // 0: healthy cell, 1: Q=Qbar=0, 2: Q stuck 0 / Qbar stuck 1
    int   fault;
    logic lq = 1'b0;

    sr_latch_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_d        (cmd_d),
        .latch_set    (latch_set),
        .latch_reset  (latch_reset),
        .latch_enable (latch_enable),
        .latch_d      (latch_d),
        .latch_q      (latch_q),
        .latch_qbar   (latch_qbar),
        .rsp_valid    (rsp_valid),
        .rsp_q        (rsp_q),
        .rsp_err      (rsp_err),
`ifdef SEQ_RETRY_EN
        .rsp_retries  (rsp_retries),
`endif
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural NOR SR latch with a gated-D front end.
    always @(latch_set or latch_reset or latch_enable or latch_d) begin
        if (latch_set) lq = 1'b1;
        else if (latch_reset) lq = 1'b0;
        else if (latch_enable) lq = latch_d;
    end

    assign latch_q    = (fault == 0) ? lq  : 1'b0;
    assign latch_qbar = (fault == 0) ? ~lq : ((fault == 1) ? 1'b0 : 1'b1);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive invariant: set/reset exclusive, enable exclusive with both.
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            assert (!(latch_set && latch_reset) && !(latch_enable && (latch_set || latch_reset))) else begin
                errors++;
                $error("FAIL drive_invariant: observed set=%0b reset=%0b enable=%0b expected exclusive",
                       latch_set, latch_reset, latch_enable);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Issue one command from a negedge and follow it to its response.
    task automatic run_cmd(input logic [1:0] op, input logic d, input int exp_lat,
                           input logic exp_q, input logic [1:0] exp_err, input int exp_pulse,
                           input int exp_retries, input string tag);
        int k;
        int pulses;
        int d_bad;
        int waited;
        waited = 0;
        while (!cmd_ready && waited < 30) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_ready"}, 32'(cmd_ready), 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_d     = d;
        @(negedge clk);
        cmd_valid = 1'b0;
        k      = 1;
        pulses = 0;
        d_bad  = 0;
        while (!rsp_valid && k < 60) begin
            if (latch_set || latch_reset || latch_enable) pulses++;
            if (latch_enable && (latch_d !== d)) d_bad++;
            @(negedge clk);
            k++;
        end
        check({tag, "_latency"}, rsp_valid ? k : 0, exp_lat);
        check({tag, "_rsp_q"}, 32'(rsp_q), 32'(exp_q));
        check({tag, "_rsp_err"}, 32'(rsp_err), 32'(exp_err));
        check({tag, "_pulse_cycles"}, pulses, exp_pulse);
        check({tag, "_d_stable"}, d_bad, 0);
        check({tag, "_ready_in_rsp"}, 32'(cmd_ready), 1);
`ifdef SEQ_RETRY_EN
        check({tag, "_retries"}, 32'(rsp_retries), exp_retries);
`endif
        @(negedge clk);
        check({tag, "_rsp_oneshot"}, 32'(rsp_valid), 0);
    endtask

    int         n_rsp;
    int         k;
    int         exp_lat;
    logic [1:0] op_i;
    logic       d_i;
    logic       m_q;

    initial begin
        errors    = 0;
        checks    = 0;
        fault     = 0;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_d     = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_drives", 32'({latch_set, latch_reset, latch_enable, latch_d}), 0);
        check("rst_rsp_fields", 32'({rsp_q, rsp_err}), 0);
        check("rst_ready", 32'(cmd_ready), 1);
        rst = 1'b0;
        @(negedge clk);

        // Reset in the middle of an op01 pulse.
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        cmd_d     = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("midrst_setup_set_low", 32'(latch_set), 0);
        @(negedge clk);
        check("midrst_pulse_set_high", 32'(latch_set), 1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_set_dropped", 32'(latch_set), 0);
        check("midrst_busy_cleared", 32'(busy), 0);
        rst   = 1'b0;
        n_rsp = 0;
        repeat (2) begin
            @(negedge clk);
            if (rsp_valid) n_rsp++;
        end
        check("midrst_ready", 32'(cmd_ready), 1);
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid) n_rsp++;
        end
        check("midrst_no_rsp", n_rsp, 0);

        // First hold after reset is unchecked, even against a stuck cell.
        fault = 2;
        run_cmd(2'b00, 1'b0, 6, 1'b0, 2'b00, 0, 0, "hold_unchecked");
        fault = 0;

        // Set then reset on a healthy cell.
        run_cmd(2'b01, 1'b0, 8, 1'b1, 2'b00, 2, 0, "set");
        run_cmd(2'b10, 1'b0, 8, 1'b0, 2'b00, 2, 0, "reset");

        // Gated-D writes followed by holds.
        run_cmd(2'b11, 1'b1, 8, 1'b1, 2'b00, 2, 0, "write1");
        run_cmd(2'b00, 1'b0, 6, 1'b1, 2'b00, 0, 0, "hold1");
        run_cmd(2'b11, 1'b0, 8, 1'b0, 2'b00, 2, 0, "write0");
        run_cmd(2'b00, 1'b1, 6, 1'b0, 2'b00, 0, 0, "hold0");

        // Q==Qbar is invalid and never retried.
        fault = 1;
        run_cmd(2'b01, 1'b0, 8, 1'b0, 2'b10, 2, 0, "invalid");

        // Stuck Q=0 on a set: mismatch, retried three pulses when enabled.
        fault = 2;
        run_cmd(2'b01, 1'b0, RETRY ? 22 : 8, 1'b0, 2'b01, RETRY ? 6 : 2, RETRY ? 2 : 0, "mismatch_set");

        // Shadow is 1 now: healthy hold passes, stuck hold mismatches.
        fault = 0;
        run_cmd(2'b00, 1'b0, 6, 1'b1, 2'b00, 0, 0, "hold_shadow_ok");
        fault = 2;
        run_cmd(2'b00, 1'b0, RETRY ? 16 : 6, 1'b0, 2'b01, 0, RETRY ? 2 : 0, "hold_shadow_bad");
        fault = 0;

        // Back-to-back random stream with cmd_valid held high.
        m_q       = 1'b1;
        cmd_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            op_i = 2'($urandom_range(0, 3));
            d_i  = 1'($urandom_range(0, 1));
            check("b2b_ready", 32'(cmd_ready), 1);
            cmd_op = op_i;
            cmd_d  = d_i;
            case (op_i)
                2'b01:   m_q = 1'b1;
                2'b10:   m_q = 1'b0;
                2'b11:   m_q = d_i;
                default: m_q = m_q;
            endcase
            exp_lat = (op_i == 2'b00) ? 6 : 8;
            k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (!rsp_valid && k < 40);
            check("b2b_latency", rsp_valid ? k : 0, exp_lat);
            check("b2b_rsp_q", 32'(rsp_q), 32'(m_q));
            check("b2b_rsp_err", 32'(rsp_err), 0);
        end
        cmd_valid = 1'b0;
        @(negedge clk);
        check("b2b_no_extra_accept", 32'(busy), 0);
        check("b2b_no_extra_rsp", 32'(rsp_valid), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
